// File: rtl/kernel_ram_pkg.sv
// Shared definitions for the kernel RAM arbiter: default geometry of the
// 10240x32 on-chip RAM and the requester index type.
package kernel_ram_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 10240;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

endpackage

// File: rtl/kernel_ram_rr_grant.sv
// Two-way round-robin grant. On contention the port that did not win last
// time is granted; `last` follows every granted request.
module kernel_ram_rr_grant
   import kernel_ram_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  req0_i,
   input  logic  req1_i,
   output logic  gnt0_o,
   output logic  gnt1_o,
   output port_e win_o
);

   port_e last_q, last_d;
   logic  valid;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      win_o  = PORT0;
      valid  = reset_n & (req0_i | req1_i);
      last_d = last_q;
      if (req0_i && req1_i)
         win_o = (last_q == PORT0) ? PORT1 : PORT0;
      else if (req1_i)
         win_o = PORT1;
      if (valid)
         last_d = win_o;
   end

   assign gnt0_o = valid & (win_o == PORT0);
   assign gnt1_o = valid & (win_o == PORT1);

   // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!reset_n)
         last_q <= PORT1;
      else
         last_q <= last_d;
   end

endmodule

// File: rtl/kernel_ram_arbiter.sv
// Round-robin arbiter sharing the single-port kernel RAM between the Nios II
// data master (port 0) and the DDS table engine (port 1).
module kernel_ram_arbiter #(
   parameter int ADDR_W = kernel_ram_pkg::ADDR_W,
   parameter int DATA_W = kernel_ram_pkg::DATA_W,
   parameter int DEPTH  = kernel_ram_pkg::DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     p0_address,
   input  logic [DATA_W/8-1:0]   p0_byteenable,
   input  logic                  p0_read,
   input  logic                  p0_write,
   input  logic [DATA_W-1:0]     p0_writedata,
   output logic                  p0_waitrequest,
   output logic [DATA_W-1:0]     p0_readdata,
   output logic                  p0_readdatavalid,
   input  logic [ADDR_W-1:0]     p1_address,
   input  logic [DATA_W/8-1:0]   p1_byteenable,
   input  logic                  p1_read,
   input  logic                  p1_write,
   input  logic [DATA_W-1:0]     p1_writedata,
   output logic                  p1_waitrequest,
   output logic [DATA_W-1:0]     p1_readdata,
   output logic                  p1_readdatavalid,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic                  ram_clken,
   output logic [DATA_W-1:0]     ram_writedata,
   input  logic [DATA_W-1:0]     ram_readdata
);
   import kernel_ram_pkg::*;

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   logic                gnt0, gnt1, accept, in_range, rd_acc;
   port_e               win;
   logic                w_rd, w_wr;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W/8-1:0] w_be;
   logic [DATA_W-1:0]   w_wdata;

   logic  rd_pend_q, rd_pend_d;
   port_e rd_port_q, rd_port_d;
   logic  rd_oor_q,  rd_oor_d;

   kernel_ram_rr_grant u_grant (
      .clk     (clk),
      .reset_n (reset_n),
      .req0_i  (p0_read | p0_write),
      .req1_i  (p1_read | p1_write),
      .gnt0_o  (gnt0),
      .gnt1_o  (gnt1),
      .win_o   (win)
   );

   always_comb begin
      w_rd    = p0_read;
      w_wr    = p0_write;
      w_addr  = p0_address;
      w_be    = p0_byteenable;
      w_wdata = p0_writedata;
      if (win == PORT1) begin
         w_rd    = p1_read;
         w_wr    = p1_write;
         w_addr  = p1_address;
         w_be    = p1_byteenable;
         w_wdata = p1_writedata;
      end
   end

   // Out-of-range commands are still accepted but never reach the RAM.
   assign accept         = gnt0 | gnt1;
   assign in_range       = {1'b0, w_addr} < DEPTH_C;
   assign rd_acc         = accept & w_rd & ~w_wr;
   assign ram_chipselect = accept & in_range;
   assign ram_write      = ram_chipselect & w_wr;
   assign ram_address    = w_addr;
   assign ram_byteenable = w_be;
   assign ram_writedata  = w_wdata;
   assign ram_clken      = reset_n;

   assign p0_waitrequest = ~reset_n | ((p0_read | p0_write) & ~gnt0);
   assign p1_waitrequest = ~reset_n | ((p1_read | p1_write) & ~gnt1);

   always_comb begin
      rd_pend_d = rd_acc;
      rd_port_d = rd_port_q;
      rd_oor_d  = rd_oor_q;
      if (rd_acc) begin
         rd_port_d = win;
         rd_oor_d  = ~in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_pend_q <= 1'b0;
         rd_port_q <= PORT0;
         rd_oor_q  <= 1'b0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
         rd_oor_q  <= rd_oor_d;
      end
   end

   // A return in flight when reset asserts is dropped, hence the reset_n gate.
   assign p0_readdatavalid = reset_n & rd_pend_q & (rd_port_q == PORT0);
   assign p1_readdatavalid = reset_n & rd_pend_q & (rd_port_q == PORT1);
   assign p0_readdata = (p0_readdatavalid & ~rd_oor_q) ? ram_readdata : '0;
   assign p1_readdata = (p1_readdatavalid & ~rd_oor_q) ? ram_readdata : '0;

endmodule

// File: tb/tb_kernel_ram_arbiter.sv
// Directed bench for kernel_ram_arbiter with a behavioural 10240x32 RAM
// whose q is valid one clock after the address.
module tb_kernel_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [13:0] p0_address, p1_address;
   logic [3:0]  p0_byteenable, p1_byteenable;
   logic        p0_read, p0_write, p1_read, p1_write;
   logic [31:0] p0_writedata, p1_writedata;
   logic        p0_waitrequest, p1_waitrequest;
   logic [31:0] p0_readdata, p1_readdata;
   logic        p0_readdatavalid, p1_readdatavalid;
   logic [13:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata;
   logic [31:0] ram_q;

   logic [31:0] mem [0:10239];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   kernel_ram_arbiter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .p0_address       (p0_address),
      .p0_byteenable    (p0_byteenable),
      .p0_read          (p0_read),
      .p0_write         (p0_write),
      .p0_writedata     (p0_writedata),
      .p0_waitrequest   (p0_waitrequest),
      .p0_readdata      (p0_readdata),
      .p0_readdatavalid (p0_readdatavalid),
      .p1_address       (p1_address),
      .p1_byteenable    (p1_byteenable),
      .p1_read          (p1_read),
      .p1_write         (p1_write),
      .p1_writedata     (p1_writedata),
      .p1_waitrequest   (p1_waitrequest),
      .p1_readdata      (p1_readdata),
      .p1_readdatavalid (p1_readdatavalid),
      .ram_address      (ram_address),
      .ram_byteenable   (ram_byteenable),
      .ram_chipselect   (ram_chipselect),
      .ram_write        (ram_write),
      .ram_clken        (ram_clken),
      .ram_writedata    (ram_writedata),
      .ram_readdata     (ram_q)
   );

   // RAM model; word 0 is seeded with a marker while clken is low.
   always @(posedge clk) begin
      if (!ram_clken) begin
         mem[0] <= 32'hA5A5A5A5;
      end else if (ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b])
                  mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_q <= mem[ram_address];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n0, n1, w;
      reset_n       = 1'b0;
      p0_address    = 14'h0000;
      p1_address    = 14'h0001;
      p0_byteenable = 4'hF;
      p1_byteenable = 4'hF;
      p0_read       = 1'b1;
      p1_read       = 1'b1;
      p0_write      = 1'b0;
      p1_write      = 1'b0;
      p0_writedata  = '0;
      p1_writedata  = '0;

      // Reset held 3 clocks with both ports requesting.
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("rst_p0_wait", p0_waitrequest, 1);
         check("rst_p1_wait", p1_waitrequest, 1);
         check("rst_cs", ram_chipselect, 0);
         check("rst_wr", ram_write, 0);
         check("rst_clken", ram_clken, 0);
         check("rst_p0_rdv", p0_readdatavalid, 0);
         check("rst_p1_rdv", p1_readdatavalid, 0);
         check("rst_p0_rd", p0_readdata, 0);
      end

      // Release: port 0 wins the first contention.
      reset_n = 1'b1;
      #1;
      check("rel_p0_wait", p0_waitrequest, 0);
      check("rel_p1_wait", p1_waitrequest, 1);
      check("rel_cs", ram_chipselect, 1);
      check("rel_addr", ram_address, 14'h0000);
      check("rel_clken", ram_clken, 1);
      p0_read = 1'b0;
      p1_read = 1'b0;
      #1;
      check("idle_p0_wait", p0_waitrequest, 0);
      check("idle_p1_wait", p1_waitrequest, 0);
      check("idle_cs", ram_chipselect, 0);
      cycle();

      // Single port write then read.
      p1_write = 1'b1; p1_address = 14'h0010; p1_byteenable = 4'hF; p1_writedata = 32'hDEADBEEF;
      #1;
      check("sp_wr_wait", p1_waitrequest, 0);
      check("sp_wr_cs", ram_chipselect, 1);
      check("sp_wr_we", ram_write, 1);
      check("sp_wr_addr", ram_address, 14'h0010);
      check("sp_wr_data", ram_writedata, 32'hDEADBEEF);
      cycle();
      p1_write = 1'b0; p1_read = 1'b1;
      #1;
      check("sp_rd_wait", p1_waitrequest, 0);
      check("sp_rd_cs", ram_chipselect, 1);
      check("sp_rd_we", ram_write, 0);
      cycle();
      p1_read = 1'b0;
      check("sp_rdv", p1_readdatavalid, 1);
      check("sp_rdata", p1_readdata, 32'hDEADBEEF);
      check("sp_p0_rdv", p0_readdatavalid, 0);
      cycle();
      check("sp_rdv_once", p1_readdatavalid, 0);

      // Byte enables.
      p1_write = 1'b1; p1_address = 14'h0020; p1_byteenable = 4'hF; p1_writedata = 32'hFFFFFFFF;
      cycle();
      p1_byteenable = 4'h5; p1_writedata = 32'h00000000;
      cycle();
      p1_write = 1'b0; p1_read = 1'b1; p1_byteenable = 4'hF;
      cycle();
      p1_read = 1'b0;
      check("be_rdv", p1_readdatavalid, 1);
      check("be_rdata", p1_readdata, 32'hFF00FF00);

      // Contention: 4 reads each, strict alternation starting with port 0.
      p0_read = 1'b1; p0_address = 14'h0010;
      p1_read = 1'b1; p1_address = 14'h0020;
      n0 = 0; n1 = 0;
      for (int k = 0; k < 8; k++) begin
         w = k % 2;
         #1;
         check("ct_p0_wait", p0_waitrequest, (n0 < 4) && (w == 1));
         check("ct_p1_wait", p1_waitrequest, (n1 < 4) && (w == 0));
         check("ct_addr", ram_address, (w == 0) ? 14'h0010 : 14'h0020);
         cycle();
         if (w == 0) n0++; else n1++;
         if (n0 == 4) p0_read = 1'b0;
         if (n1 == 4) p1_read = 1'b0;
         check("ct_p0_rdv", p0_readdatavalid, w == 0);
         check("ct_p1_rdv", p1_readdatavalid, w == 1);
         if (w == 0) check("ct_p0_rdata", p0_readdata, 32'hDEADBEEF);
         else        check("ct_p1_rdata", p1_readdata, 32'hFF00FF00);
      end

      // Out-of-range write and read at address 10240.
      p0_write = 1'b1; p0_address = 14'd10240; p0_byteenable = 4'hF; p0_writedata = 32'h12345678;
      #1;
      check("oor_wr_wait", p0_waitrequest, 0);
      check("oor_wr_cs", ram_chipselect, 0);
      cycle();
      p0_write = 1'b0; p0_read = 1'b1;
      #1;
      check("oor_rd_wait", p0_waitrequest, 0);
      check("oor_rd_cs", ram_chipselect, 0);
      cycle();
      p0_read = 1'b0;
      check("oor_rdv", p0_readdatavalid, 1);
      check("oor_rdata", p0_readdata, 0);
      p0_read = 1'b1; p0_address = 14'h0000;
      cycle();
      p0_read = 1'b0;
      check("w0_rdv", p0_readdatavalid, 1);
      check("w0_rdata", p0_readdata, 32'hA5A5A5A5);

      // Reset asserted the clock after a read is accepted.
      p0_read = 1'b1; p0_address = 14'h0010;
      #1;
      check("mr_acc_wait", p0_waitrequest, 0);
      cycle();
      p0_read = 1'b0;
      reset_n = 1'b0;
      #1;
      check("mr_p0_rdv", p0_readdatavalid, 0);
      check("mr_p0_wait", p0_waitrequest, 1);
      cycle();
      check("mr_p0_rdv2", p0_readdatavalid, 0);
      reset_n = 1'b1;
      p0_read = 1'b1; p1_read = 1'b1;
      #1;
      check("mr_rel_p0_wait", p0_waitrequest, 0);
      check("mr_rel_p1_wait", p1_waitrequest, 1);
      p0_read = 1'b0;
      p1_address = 14'h0020;
      #1;
      check("mr_p1_wait", p1_waitrequest, 0);
      cycle();
      p1_read = 1'b0;
      check("mr_p1_rdv", p1_readdatavalid, 1);
      check("mr_p1_rdata", p1_readdata, 32'hFF00FF00);
      check("mr_p0_rdv3", p0_readdatavalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kernel_ram_arbiter.md
# kernel_ram_arbiter

Two-port round-robin arbiter that shares the single-port 10240×32 on-chip RAM between the Nios II data master (port 0) and the DDS waveform-table engine (port 1). It sits between both Avalon-MM masters and the RAM's s1 slave. Each requester gets waitrequest/readdatavalid flow control. Out-of-range accesses are absorbed without touching memory.

## Interface
Parameters:
- ADDR_W, 14, word-address width of both requesters and the RAM
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 10240, number of implemented RAM words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  single system clock
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- pN_address  in  ADDR_W  requester N word address (N = 0, 1)
- pN_byteenable  in  DATA_W/8  requester N byte lanes
- pN_read, pN_write  in  1  requester N command; both high is illegal and treated as write
- pN_writedata  in  DATA_W  requester N write data
- pN_waitrequest  out  1  command not accepted this cycle
- pN_readdata  out  DATA_W  read return data
- pN_readdatavalid  out  1  one-cycle strobe qualifying pN_readdata
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  DATA_W/8  to RAM
- ram_chipselect, ram_write, ram_clken  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_readdata  in  DATA_W  from RAM; unregistered q, valid one clk after address

## Operation
- Per cycle, at most one command is accepted. Grant is combinational from pN_read|pN_write and the priority pointer `last`.
- Only one port requesting: that port is granted.
- Both ports requesting: the port != `last` is granted. `last` updates to the granted port on every accepted command.
- Granted port: waitrequest=0. Other requesting port: waitrequest=1. Idle port: waitrequest=0 (Avalon don't-care).
- While in reset: pN_waitrequest=1.
- Accepted in-range command: ram_chipselect=1, ram_address/byteenable/writedata muxed from the winner, ram_write=winner's write.
- Out-of-range write (address >= DEPTH): accepted, ram_chipselect=0, no memory change.
- Out-of-range read: accepted, ram_chipselect=0, returns data 0 with the normal latency.
- Return tracking register: rd_pend (1 b), rd_port (1 b), rd_oor (1 b), set on every accepted read.
- Cycle after an accepted read: prd_port_readdatavalid=1 and readdata = rd_oor ? 0 : ram_readdata. The other port's readdatavalid=0.
- Writes produce no response.
- ram_clken is tied 1 after reset, 0 during reset.
- Reset values: all waitrequest=1, readdatavalid=0, readdata=0, ram_chipselect=0, ram_write=0, last=1 (port 0 wins the first contention), rd_pend=0.
- Reset asserted mid-operation: any pending read return is discarded and no readdatavalid is issued. Requesters must reissue.

## Timing
- Read latency is fixed at 1 clk from acceptance (waitrequest=0 with read high) to readdatavalid.
- Reads are fully pipelined: back-to-back reads by either port sustain 1 per clk.
- A write accepted the cycle after a read does not disturb that read's return.
- Worst-case wait for a persistent requester under continuous contention is 1 clk (strict alternation).
- readdata and readdatavalid are registered outputs. All other outputs are combinational from the current request and registered state.

## Structure
- Shared package kernel_ram_pkg: ADDR_W, DATA_W, DEPTH, and the port-index type (PORT0=0, PORT1=1).
- Natural sub-module: kernel_ram_rr_grant (2-way round-robin grant plus `last` pointer), reusable for later peripherals.
- The return-tracking register stays in the top module.

## Test plan
- Reset: hold reset_n=0 for 3 clk with both ports requesting -> waitrequest=1, ram_chipselect=0, readdatavalid=0 throughout. After release, port 0 is granted first.
- Single port: p1 writes 0xDEADBEEF to 0x0010 (byteenable 0xF), then reads 0x0010 -> p1_readdatavalid exactly 1 clk after read acceptance with 0xDEADBEEF. p0 sees no valid.
- Byte enables: write 0xFFFFFFFF then 0x00000000 with byteenable 0x5 to 0x0020; read -> 0xFF00FF00.
- Contention: both ports issue 4 continuous reads -> grants alternate p0,p1,p0,p1…. Every readdatavalid is on the correct port with the correct data. Each port is stalled at most 1 clk per command.
- Out of range: p0 writes 0x12345678 to 10240, then reads 10240 -> ram_chipselect=0 both times, readdata=0 with valid at normal latency. Word 0 is unchanged.
- Reset mid-read: accept a read on p0, then assert reset_n=0 the next clk -> no p0_readdatavalid. After release, normal operation resumes.
